chess_turn_scheduler: RTL
=========================

CHESS_TURN_SCHEDULER -- requirements
Module: chess_turn_scheduler

Interface
REQ-001 SHALL have parameter p_INC_W, default 4, meaning bit width of the per-move increment in seconds.
REQ-002 SHALL have parameter p_MOVE_W, default 8, meaning bit width of the move counter.
REQ-003 SHALL have port i_clk  input  1  system clock (50 MHz); all logic clocked on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_restart  input  1  one-cycle debounced click: restart game.
REQ-006 SHALL have port i_stop  input  1  one-cycle debounced click: pause/resume.
REQ-007 SHALL have ports i_player_a / i_player_b  input  1 each  one-cycle click: that player ends the move.
REQ-008 SHALL have ports i_player_a_zero / i_player_b_zero  input  1 each  level: that player's counter is at 00.
REQ-009 SHALL have ports i_player_a_full / i_player_b_full  input  1 each  level: that player's counter is at 99.
REQ-010 SHALL have port i_increment  input  p_INC_W  Fischer increment, seconds per completed move.
REQ-011 SHALL have ports o_player_a_stop / o_player_b_stop  output  1 each  high = freeze that player's clock divider.
REQ-012 SHALL have ports o_player_a_plus / o_player_b_plus  output  1 each  one-cycle +1 s pulse to that player's counter.
REQ-013 SHALL have ports o_player_a_win / o_player_b_win  output  1 each  level: that player has won on time.
REQ-014 SHALL have port o_restart  output  1  one-cycle pulse: reset counters and dividers.
REQ-015 SHALL have port o_moves  output  p_MOVE_W  completed moves since restart.
REQ-016 SHALL have port o_busy  output  1  high while an increment burst is in progress.

Function
REQ-017 SHALL implement states IDLE, RUN_A, RUN_B, INC_A, INC_B, PAUSE, FLAG_A, FLAG_B; all outputs registered, visible the cycle after the causing input.
REQ-018 SHALL apply input priority restart > zero > stop > player click when several are valid in one cycle.
REQ-019 SHALL on i_restart in any state go to IDLE, pulse o_restart once, clear o_moves, clear both win outputs, abort any burst.
REQ-020 SHALL in IDLE hold both stops high; i_player_a -> RUN_B, i_player_b -> RUN_A; no increment, no move counted.
REQ-021 SHALL in RUN_A drive o_player_a_stop=0, o_player_b_stop=1 (mirror for RUN_B); the clicks of the player not running are ignored.
REQ-022 SHALL in RUN_A on i_player_a latch i_increment into a burst counter and enter INC_A; if latched value is 0 go directly to RUN_B and count the move.
REQ-023 SHALL in INC_A hold both stops high, o_busy=1, issue o_player_a_plus on alternate cycles (first the cycle after entry) until the burst count is exhausted, then enter RUN_B and count the move; INC_B mirrors.
REQ-024 SHALL suppress a plus pulse and end the burst early (next state RUN_B/RUN_A, move counted) when the target's i_*_full is high on a pulse cycle.
REQ-025 SHALL ignore i_stop and all player clicks during INC_A/INC_B.
REQ-026 SHALL in RUN_A on i_player_a_zero enter FLAG_A, set o_player_b_win=1, hold both stops high until restart (FLAG_B mirrors); zero wins over a same-cycle click.
REQ-027 SHALL on i_stop in RUN_x enter PAUSE remembering the side, both stops high; i_stop in PAUSE resumes that RUN_x; player clicks in PAUSE ignored.
REQ-028 SHALL increment o_moves on each completed move, saturating at all-ones.

Reset
REQ-029 SHALL on i_rst enter IDLE with o_player_a_stop=o_player_b_stop=1, all plus pulses 0, both wins 0, o_restart 0, o_moves 0, o_busy 0, burst counter 0.
REQ-030 SHALL give i_rst priority over every other input, including mid-burst.

Structure
REQ-031 SHALL take the state enum typedef and default widths from shared package chess_clock_pkg.
REQ-032 SHALL be a single module with no sub-modules; burst counter, pause-side bit and move counter inline.

Verification
REQ-033 SHALL check: reset, b click, a-side ran, a click with i_increment=3 -> a_plus at entry+1,+3,+5, RUN_B after, o_moves=1.
REQ-034 SHALL check: RUN_A, i_player_a_zero and i_player_a same cycle -> FLAG_A, o_player_b_win=1, no plus pulses.
REQ-035 SHALL check: INC_A with i_increment=5, i_player_a_full raised before 3rd pulse -> exactly 2 pulses, RUN_B, o_moves incremented.
REQ-036 SHALL check: RUN_B, stop -> both stops 1; a/b clicks ignored; stop -> RUN_B resumes, o_player_b_stop=0.
REQ-037 SHALL check: restart mid-INC_B with 255 moves -> one o_restart pulse, IDLE, o_moves=0, no further plus pulses.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and default widths for the chess clock turn scheduler.
package chess_clock_pkg;

  // Default width of the Fischer increment (seconds per completed move)
  localparam int DEF_INC_W  = 4;

  // Default width of the completed-move counter
  localparam int DEF_MOVE_W = 8;

  // Scheduler states: who is running, who is being credited, or why play is frozen
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_A  = 3'd1,
    RUN_B  = 3'd2,
    INC_A  = 3'd3,
    INC_B  = 3'd4,
    PAUSE  = 3'd5,
    FLAG_A = 3'd6,
    FLAG_B = 3'd7
  } turn_state_t;

  // Freeze controls for the two players' clock dividers
  typedef struct packed {
    logic a_stop;
    logic b_stop;
  } stop_pair_t;

  // A player's divider only runs while that player is on move and nothing else is going on
  function automatic stop_pair_t stops_for(input turn_state_t s);
    stop_pair_t p;
    p.a_stop = (s != RUN_A);
    p.b_stop = (s != RUN_B);
    return p;
  endfunction

endpackage

// File: rtl/chess_turn_scheduler.sv
// Turn scheduler for a two-player chess clock: decides whose clock runs,
// credits the Fischer increment as a burst of +1 s pulses, handles pause,
// flag fall and restart. Every output is registered.
module chess_turn_scheduler
  import chess_clock_pkg::*;
#(
  parameter int p_INC_W  = DEF_INC_W,
  parameter int p_MOVE_W = DEF_MOVE_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_restart,
  input  logic                i_stop,
  input  logic                i_player_a,
  input  logic                i_player_b,
  input  logic                i_player_a_zero,
  input  logic                i_player_b_zero,
  input  logic                i_player_a_full,
  input  logic                i_player_b_full,
  input  logic [p_INC_W-1:0]  i_increment,
  output logic                o_player_a_stop,
  output logic                o_player_b_stop,
  output logic                o_player_a_plus,
  output logic                o_player_b_plus,
  output logic                o_player_a_win,
  output logic                o_player_b_win,
  output logic                o_restart,
  output logic [p_MOVE_W-1:0] o_moves,
  output logic                o_busy
);

  turn_state_t         state;
  turn_state_t         state_nxt;
  logic [p_INC_W-1:0]  burst_cnt;
  logic [p_INC_W-1:0]  burst_nxt;
  logic                gap_cycle;
  logic                gap_nxt;
  logic                pause_side;
  logic                side_nxt;
  logic [p_MOVE_W-1:0] move_cnt;
  logic                count_move;
  logic                clear_moves;
  logic                plus_a_nxt;
  logic                plus_b_nxt;
  logic                restart_nxt;
  stop_pair_t          stops_nxt;
  logic                busy_nxt;
  logic                win_a_nxt;
  logic                win_b_nxt;

  // State register plus the inline burst counter, pulse spacing bit, pause side and move counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      gap_cycle  <= 1'b0;
      pause_side <= 1'b0;
      move_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      gap_cycle  <= gap_nxt;
      pause_side <= side_nxt;
      if (clear_moves) begin
        move_cnt <= '0;
      end else if (count_move && (move_cnt != '1)) begin
        move_cnt <= move_cnt + p_MOVE_W'(1);
      end
    end
  end

  // Next-state logic; restart beats flag fall beats pause beats a player's click
  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    gap_nxt     = gap_cycle;
    side_nxt    = pause_side;
    count_move  = 1'b0;
    clear_moves = 1'b0;
    plus_a_nxt  = 1'b0;
    plus_b_nxt  = 1'b0;
    restart_nxt = 1'b0;

    if (i_restart) begin
      state_nxt   = IDLE;
      burst_nxt   = '0;
      gap_nxt     = 1'b0;
      clear_moves = 1'b1;
      restart_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // The player who clicks first hands the move to the opponent
          if (i_player_a) begin
            state_nxt = RUN_B;
          end else if (i_player_b) begin
            state_nxt = RUN_A;
          end
        end

        RUN_A: begin
          if (i_player_a_zero) begin
            state_nxt = FLAG_A;
          end else if (i_stop) begin
            state_nxt = PAUSE;
            side_nxt  = 1'b0;
          end else if (i_player_a) begin
            if (i_increment == '0) begin
              state_nxt  = RUN_B;
              count_move = 1'b1;
            end else begin
              state_nxt = INC_A;
              burst_nxt = i_increment;
              gap_nxt   = 1'b0;
            end
          end
        end

        RUN_B: begin
          if (i_player_b_zero) begin
            state_nxt = FLAG_B;
          end else if (i_stop) begin
            state_nxt = PAUSE;
            side_nxt  = 1'b1;
          end else if (i_player_b) begin
            if (i_increment == '0) begin
              state_nxt  = RUN_A;
              count_move = 1'b1;
            end else begin
              state_nxt = INC_B;
              burst_nxt = i_increment;
              gap_nxt   = 1'b0;
            end
          end
        end

        INC_A: begin
          // Pulses go out every other cycle so the counter sees distinct edges
          if (gap_cycle) begin
            gap_nxt = 1'b0;
          end else if (i_player_a_full) begin
            state_nxt  = RUN_B;
            burst_nxt  = '0;
            count_move = 1'b1;
          end else begin
            plus_a_nxt = 1'b1;
            burst_nxt  = burst_cnt - p_INC_W'(1);
            gap_nxt    = 1'b1;
            if (burst_cnt <= p_INC_W'(1)) begin
              state_nxt  = RUN_B;
              burst_nxt  = '0;
              gap_nxt    = 1'b0;
              count_move = 1'b1;
            end
          end
        end

        INC_B: begin
          if (gap_cycle) begin
            gap_nxt = 1'b0;
          end else if (i_player_b_full) begin
            state_nxt  = RUN_A;
            burst_nxt  = '0;
            count_move = 1'b1;
          end else begin
            plus_b_nxt = 1'b1;
            burst_nxt  = burst_cnt - p_INC_W'(1);
            gap_nxt    = 1'b1;
            if (burst_cnt <= p_INC_W'(1)) begin
              state_nxt  = RUN_A;
              burst_nxt  = '0;
              gap_nxt    = 1'b0;
              count_move = 1'b1;
            end
          end
        end

        PAUSE: begin
          if (i_stop) begin
            state_nxt = pause_side ? RUN_B : RUN_A;
          end
        end

        FLAG_A, FLAG_B: begin
          state_nxt = state;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode from the state being entered, so outputs line up with it after the register
  always_comb begin
    stops_nxt = stops_for(state_nxt);
    busy_nxt  = (state_nxt == INC_A) || (state_nxt == INC_B);
    win_a_nxt = (state_nxt == FLAG_B);
    win_b_nxt = (state_nxt == FLAG_A);
  end

  // Output register: one-cycle delay from cause to every visible output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_player_a_stop <= 1'b1;
      o_player_b_stop <= 1'b1;
      o_player_a_plus <= 1'b0;
      o_player_b_plus <= 1'b0;
      o_player_a_win  <= 1'b0;
      o_player_b_win  <= 1'b0;
      o_restart       <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_player_a_stop <= stops_nxt.a_stop;
      o_player_b_stop <= stops_nxt.b_stop;
      o_player_a_plus <= plus_a_nxt;
      o_player_b_plus <= plus_b_nxt;
      o_player_a_win  <= win_a_nxt;
      o_player_b_win  <= win_b_nxt;
      o_restart       <= restart_nxt;
      o_busy          <= busy_nxt;
    end
  end

  assign o_moves = move_cnt;

endmodule
